// File: rtl/hamming_pkg.sv
// ---------------------------------------------------------------------------
// hamming_pkg
//
// Purpose:
//    Shared definitions for the Hamming(15,11) transmit serializer and the
//    matching decoder. Holds the code geometry, the parity and data index
//    maps, the FSM state type and the encode/syndrome/extract helpers.
//    Both ends of the link import this package, so the bit layout is
//    defined in exactly one place.
//
// Codeword layout (index 0..14, position = index + 1):
//    parity bits at indices 0, 1, 3, 7 (positions 1, 2, 4, 8)
//    data bits d0..d10 at indices 2, 4, 5, 6, 8, 9, 10, 11, 12, 13, 14
//
// Ports: none (package).
// ---------------------------------------------------------------------------
package hamming_pkg;

   localparam int DATA_W = 11;
   localparam int CODE_W = 15;
   localparam int PAR_W  = 4;

   // Parity bits live at the power-of-two positions (index = position - 1)
   localparam int PARITY_IDX [PAR_W] = '{0, 1, 3, 7};

   // Data bit i is placed at codeword index DATA_IDX[i]
   localparam int DATA_IDX [DATA_W] = '{2, 4, 5, 6, 8, 9, 10, 11, 12, 13, 14};

   // Serializer FSM states
   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } tx_state_e;

   // Builds the codeword: scatter the data bits, then each parity bit p
   // covers every position whose binary form has bit p set. Parity
   // positions never overlap another parity group, so they are still zero
   // when the later groups are folded.
   function automatic logic [CODE_W-1:0] hamming15_encode(input logic [DATA_W-1:0] d);
      logic [CODE_W-1:0] cw;
      logic              par;
      cw  = '0;
      par = 1'b0;
      for (int i = 0; i < DATA_W; i++) begin
         cw[DATA_IDX[i]] = d[i];
      end
      for (int p = 0; p < PAR_W; p++) begin
         par = 1'b0;
         for (int j = 0; j < CODE_W; j++) begin
            if ((((j + 1) >> p) & 1) == 1 && j != PARITY_IDX[p]) begin
               par = par ^ cw[j];
            end
         end
         cw[PARITY_IDX[p]] = par;
      end
      return cw;
   endfunction

   // Syndrome = position of a single flipped bit, 0 when the word is clean
   function automatic logic [PAR_W-1:0] hamming15_syndrome(input logic [CODE_W-1:0] cw);
      logic [PAR_W-1:0] syn;
      syn = '0;
      for (int j = 0; j < CODE_W; j++) begin
         if (cw[j]) begin
            syn = syn ^ PAR_W'(j + 1);
         end
      end
      return syn;
   endfunction

   // Gathers the data bits back out of a (corrected) codeword
   function automatic logic [DATA_W-1:0] hamming15_extract(input logic [CODE_W-1:0] cw);
      logic [DATA_W-1:0] d;
      d = '0;
      for (int i = 0; i < DATA_W; i++) begin
         d[i] = cw[DATA_IDX[i]];
      end
      return d;
   endfunction

endpackage

// File: rtl/hamming15_enc_comb.sv
// ---------------------------------------------------------------------------
// hamming15_enc_comb
//
// Purpose:
//    Purely combinational Hamming(15,11) encoder. Kept apart from the
//    serializer FSM so the parity logic can be reused and reviewed on its
//    own.
//
// Ports:
//    data_i  [10:0]  input   data word d[10:0]
//    cw_o    [14:0]  output  encoded codeword in the shared layout
// ---------------------------------------------------------------------------
module hamming15_enc_comb
   import hamming_pkg::*;
(
   input  logic [DATA_W-1:0] data_i,
   output logic [CODE_W-1:0] cw_o
);

   // The package function unrolls to a flat XOR tree per parity bit
   assign cw_o = hamming15_encode(data_i);

endmodule

// File: rtl/hamming_tx_serializer.sv
// ---------------------------------------------------------------------------
// hamming_tx_serializer
//
// Purpose:
//    Accepts 11-bit words over a valid/ready handshake, encodes them into
//    Hamming(15,11) codewords and shifts them out one bit per accepted
//    serial beat, with start/end-of-frame markers and sink back-pressure.
//    Frames can run back to back: the next word is taken on the same edge
//    the last bit of the current frame is consumed.
//
// Parameters:
//    LSB_FIRST  1 = codeword index 0 is sent first, 0 = index 14 first
//
// Optional feature (macro HAMMING_TX_ERR_INJECT_EN):
//    Adds input err_pos[3:0]. Sampled at word accept; a non-zero value
//    inverts the transmitted bit at index err_pos-1. The codeword output
//    always shows the clean codeword.
//
// Ports:
//    clk        input   system clock, rising edge
//    rst        input   synchronous active-high reset
//    in_valid   input   in_data valid this cycle
//    in_ready   output  a word can be accepted this cycle (comb, uses ser_ready)
//    in_data    input   data word d[10:0]
//    ser_ready  input   sink accepts ser_bit this cycle
//    ser_valid  output  ser_bit is valid
//    ser_bit    output  current codeword bit
//    ser_sof    output  high with the first bit of a frame
//    ser_eof    output  high with the 15th bit of a frame
//    codeword   output  registered clean codeword of current/last frame
//    busy       output  a frame is in progress
//    err_pos    input   (HAMMING_TX_ERR_INJECT_EN only) error position 1..15
// ---------------------------------------------------------------------------
module hamming_tx_serializer
   import hamming_pkg::*;
#(
   parameter bit LSB_FIRST = 1'b1
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              ser_ready,
   output logic              ser_valid,
   output logic              ser_bit,
   output logic              ser_sof,
   output logic              ser_eof,
   output logic [CODE_W-1:0] codeword,
`ifdef HAMMING_TX_ERR_INJECT_EN
   input  logic [3:0]        err_pos,
`endif
   output logic              busy
);

   localparam logic [3:0] LAST_CNT = 4'd14;

   tx_state_e         state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [CODE_W-1:0] codeword_q, codeword_d;
   logic [CODE_W-1:0] txWord_q, txWord_d;

   logic [CODE_W-1:0] encCw;
   logic [CODE_W-1:0] errMask;
   logic [3:0]        bitIdx;
   logic              loadWord;

   hamming15_enc_comb u_enc (
      .data_i (in_data),
      .cw_o   (encCw)
   );

   // Mask applied only to the transmitted copy; position 0 means no error
`ifdef HAMMING_TX_ERR_INJECT_EN
   always_comb begin
      errMask = '0;
      if (err_pos != 4'd0) begin
         errMask[err_pos - 4'd1] = 1'b1;
      end
   end
`else
   assign errMask = '0;
`endif

   // Bit order is a pure index remap, so the counter always runs 0..14
   assign bitIdx = LSB_FIRST ? cnt_q : (LAST_CNT - cnt_q);

   // Next-state and handshake logic. in_ready depends on ser_ready so the
   // next word can be taken on the same edge that consumes the last bit.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      codeword_d = codeword_q;
      txWord_d   = txWord_q;
      in_ready   = 1'b0;
      ser_valid  = 1'b0;
      ser_bit    = 1'b0;
      ser_sof    = 1'b0;
      ser_eof    = 1'b0;
      loadWord   = 1'b0;

      unique case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               loadWord = 1'b1;
            end
         end
         SHIFT: begin
            ser_valid = 1'b1;
            ser_bit   = txWord_q[bitIdx];
            ser_sof   = (cnt_q == 4'd0);
            ser_eof   = (cnt_q == LAST_CNT);
            if (ser_ready) begin
               if (cnt_q == LAST_CNT) begin
                  in_ready = 1'b1;
                  if (in_valid) begin
                     loadWord = 1'b1;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (loadWord) begin
         state_d    = SHIFT;
         cnt_d      = 4'd0;
         codeword_d = encCw;
         txWord_d   = encCw ^ errMask;
      end
   end

   // State registers; reset aborts any frame in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         codeword_q <= '0;
         txWord_q   <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         codeword_q <= codeword_d;
         txWord_q   <= txWord_d;
      end
   end

   assign codeword = codeword_q;
   assign busy     = (state_q == SHIFT);

endmodule

// File: doc/hamming_tx_serializer.md
Name: hamming_tx_serializer

Overview:
- Transmit-side counterpart to the team's Hamming(15,11) decoder.
- Accepts 11-bit data words over a valid/ready handshake and computes the 15-bit Hamming codeword in exactly the bit layout the decoder expects.
- Shifts the codeword out bit-serially with frame markers and output back-pressure.
- Sits between the data source and the serial link or channel model that feeds the decoder.

Parameters:
- LSB_FIRST, 1, 1 = codeword index 0 is sent first; 0 = index 14 is sent first.

Ports:
- clk  input  1  single system clock; all logic is rising-edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  11  data word d[10:0].
- ser_ready  input  1  sink accepts ser_bit this cycle.
- ser_valid  output  1  ser_bit is valid.
- ser_bit  output  1  current codeword bit.
- ser_sof  output  1  high with the first bit of a frame.
- ser_eof  output  1  high with the 15th bit of a frame.
- codeword  output  15  registered codeword of the current or last frame.
- busy  output  1  a frame is in progress.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: ser_valid, ser_bit, ser_sof, ser_eof, codeword and busy are all 0, and the state is IDLE.
- Codeword layout, index 0..14 (position = index+1):
  - Parity bits at indices 0, 1, 3, 7.
  - Data mapping: d0→2, d1→4, d2→5, d3→6, d4→8, d5→9, d6→10, d7→11, d8→12, d9→13, d10→14.
  - cw[0] = ^{2,4,6,8,10,12,14}
  - cw[1] = ^{2,5,6,9,10,13,14}
  - cw[3] = ^{4,5,6,11,12,13,14}
  - cw[7] = ^{8..14}
  - The decoder must report syndrome 0 for every codeword produced.
- FSM with two states, IDLE and SHIFT, plus a 4-bit bit counter cnt (0..14).
- IDLE:
  - in_ready = 1.
  - On in_valid, the codeword is computed combinationally and loaded into the codeword register and shift register, cnt ← 0, and the FSM moves to SHIFT.
- SHIFT:
  - ser_valid = 1.
  - ser_bit = cw[cnt] when LSB_FIRST=1, else cw[14-cnt].
  - ser_sof = (cnt==0); ser_eof = (cnt==14).
  - When ser_ready=0, all outputs and cnt hold.
  - When ser_ready=1 and cnt<14, cnt increments.
  - When ser_ready=1 and cnt==14:
    - If in_valid is also high, the next word is loaded back-to-back with no gap (cnt ← 0, stay in SHIFT).
    - Otherwise the FSM returns to IDLE.
- in_ready = IDLE, or (SHIFT and cnt==14 and ser_ready). It is combinational and depends on ser_ready.
- Latency: a word accepted at edge N puts its first bit on ser_bit in cycle N+1; the last bit appears at N+15 if ser_ready is held high.
- Throughput: 1 word per 15 cycles with continuous ser_ready.
- busy = (state==SHIFT).
- codeword holds its value until the next accept.
- Mid-frame rst: the frame is aborted and ser_valid is 0 on the next cycle. No partial frame resumes; the sink discards any frame without ser_eof.
- in_data while in_ready=0 is ignored; the source must hold it.

Optional Feature:
- Macro: HAMMING_TX_ERR_INJECT_EN.
- When defined, adds input err_pos[3:0] (1..15 = position, 0 = none), sampled at word accept.
  - The transmitted bit at index err_pos-1 is inverted.
  - The codeword output stays error-free.
- When not defined, the port is absent and no bit is ever inverted.

Decomposition:
- Package hamming_pkg holds:
  - Constants DATA_W=11, CODE_W=15, PAR_W=4.
  - Parity index list {0,1,3,7}.
  - Data-to-index map.
  - Function hamming15_encode(d) → cw.
  - The decoder reuses the package.
- One natural sub-module, hamming15_enc_comb: a purely combinational encoder instantiated by the serializer, keeping the FSM separate from the parity logic.

Test Plan:
- in_data=11'h000 → codeword=15'h0000, 15 zero bits, sof in the first cycle, eof in cycle 15.
- in_data=11'h001 → codeword=15'h0007. LSB_FIRST=1 serial order is 1,1,1 followed by twelve 0s.
- in_data=11'h400 → codeword=15'h408B; in_data=11'h7FF → codeword=15'h7FFF. The decoder fed each codeword returns the original data.
- Two words with in_valid held and ser_ready=1 → second sof immediately follows first eof (30 contiguous valid cycles); in_ready pulses only at cnt==14.
- ser_ready low for 3 cycles at cnt=5 → ser_bit, cnt and sof/eof frozen; the frame completes 3 cycles late with the correct bits.
- rst asserted at cnt=7 → ser_valid=0 and busy=0 next cycle, in_ready=1. With HAMMING_TX_ERR_INJECT_EN and err_pos=5, data 11'h001 transmits 15'h0017, and the decoder corrects it back to 11'h001.
